// File: rtl/p_mul_pkg.sv
// p_mul_pkg: shared types and helpers for the packed-lane multiplier.
//   state_e     : controller states (IDLE, BUSY, DONE)
//   XLEN_*/BPS_*: legal operand widths and bits-per-step values
//   widest_sel  : index of the widest lane width selected by a pw vector
//   lane_steps  : number of steps needed to retire one lane's multiplier
package p_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned XLEN_32 = 32;
    localparam int unsigned XLEN_64 = 64;
    localparam int unsigned BPS_1   = 1;
    localparam int unsigned BPS_2   = 2;
    localparam int unsigned BPS_4   = 4;

    // Lowest set bit of pw is the widest lane; an all-zero pw falls back to
    // full-width lanes so the operation still terminates.
    function automatic logic [2:0] widest_sel(input logic [7:0] pw);
        logic [2:0] sel;
        logic       found;
        sel   = 3'd0;
        found = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pw[i] && !found) begin
                sel   = 3'(i);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [6:0] lane_steps(input int unsigned xlen,
                                              input logic [2:0]  sel,
                                              input int unsigned bps);
        return 7'((xlen >> sel) / bps);
    endfunction

endpackage

// File: rtl/p_mul_step.sv
// p_mul_step: one combinational multiply step over all lanes.
//   acc_i    : 2*XLEN accumulator, lane k in slot [2*LW*k +: 2*LW]
//   mcand_i  : multiplicand in the same slot layout, pre-shifted by prior steps
//   mplier_i : multiplier, packed lanes, pre-shifted right by prior steps
//   sel_i    : lane width index (LW = XLEN >> sel_i)
//   clmul_i  : combine partial products by XOR instead of addition
//   acc_o    : accumulator after retiring BPS multiplier bits per lane
module p_mul_step
    import p_mul_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPS  = 1,
    parameter int unsigned PWW  = $clog2(XLEN)
) (
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [2*XLEN-1:0] mcand_i,
    input  logic [XLEN-1:0]   mplier_i,
    input  logic [2:0]        sel_i,
    input  logic              clmul_i,
    output logic [2*XLEN-1:0] acc_o
);

    // bits_w[w][j][p]: multiplier bit j of the lane owning accumulator bit p,
    // for lane width index w. Spreads each lane's bit across its whole slot.
    logic [2*XLEN-1:0] bits_w [PWW][BPS];
    logic [2*XLEN-1:0] bits_sel [BPS];

    for (genvar w = 0; w < PWW; w++) begin : g_w
        localparam int unsigned LW = XLEN >> w;
        for (genvar j = 0; j < BPS; j++) begin : g_j
            for (genvar p = 0; p < 2*XLEN; p++) begin : g_p
                if (j < LW) begin : g_bit
                    assign bits_w[w][j][p] = mplier_i[(p / (2*LW)) * LW + j];
                end else begin : g_none
                    assign bits_w[w][j][p] = 1'b0;
                end
            end
        end
    end

    always_comb begin
        for (int unsigned j = 0; j < BPS; j++) begin
            bits_sel[j] = '0;
            for (int unsigned w = 0; w < PWW; w++) begin
                if (sel_i == 3'(w)) begin
                    bits_sel[j] = bits_w[w][j];
                end
            end
        end
    end

    // A lane's running sum never exceeds (2^LW-1)^2 < 2^(2*LW), so a
    // full-width add produces no carry out of any lane slot.
    always_comb begin
        logic [2*XLEN-1:0] acc;
        logic [2*XLEN-1:0] pp;
        acc = acc_i;
        pp  = '0;
        for (int unsigned j = 0; j < BPS; j++) begin
            pp  = (mcand_i << j) & bits_sel[j];
            acc = clmul_i ? (acc ^ pp) : (acc + pp);
        end
        acc_o = acc;
    end

endmodule

// File: rtl/p_mul_rx.sv
// p_mul_rx: iterative packed-lane integer / carry-less multiplier.
//   clock, resetn : rising-edge clock, asynchronous active-low reset
//   valid / ready : request held until the one-cycle ready strobe
//   mul_l / mul_h : select low (priority) or high half of each lane product
//   clmul         : carry-less product
//   pw            : one-hot lane width, pw[i] -> lanes of XLEN>>i bits
//   crs1 / crs2   : multiplicand / multiplier, packed lanes
//   result        : registered packed result, zero outside DONE
module p_mul_rx
    import p_mul_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned BPS  = 1,
    parameter int unsigned PWW  = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            valid,
    output logic            ready,
    input  logic            mul_l,
    input  logic            mul_h,
    input  logic            clmul,
    input  logic [PWW-1:0]  pw,
    input  logic [XLEN-1:0] crs1,
    input  logic [XLEN-1:0] crs2,
    output logic [XLEN-1:0] result
);

    state_e            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [2*XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0]   mplier_q, mplier_d;
    logic [2:0]        sel_q, sel_d;
    logic              mul_l_q, mul_l_d;
    logic              mul_h_q, mul_h_d;
    logic              clmul_q, clmul_d;
    logic              ready_q, ready_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic [2:0]        sel_in;
    logic [6:0]        steps;
    logic [2*XLEN-1:0] step_acc;
    logic [2*XLEN-1:0] mcand_sel;
    logic [XLEN-1:0]   lo_sel, hi_sel;

    logic [2*XLEN-1:0] mcand_w [PWW];
    logic [XLEN-1:0]   lo_w    [PWW];
    logic [XLEN-1:0]   hi_w    [PWW];

    assign sel_in = widest_sel(8'(pw));
    assign steps  = lane_steps(XLEN, sel_q, BPS);

    // Per lane width: spread crs1 lanes into 2*LW slots, and gather the low
    // and high LW bits of each accumulator slot back into packed lanes.
    for (genvar w = 0; w < PWW; w++) begin : g_w
        localparam int unsigned LW = XLEN >> w;
        for (genvar p = 0; p < 2*XLEN; p++) begin : g_exp
            if ((p % (2*LW)) < LW) begin : g_src
                assign mcand_w[w][p] = crs1[(p / (2*LW)) * LW + (p % (2*LW))];
            end else begin : g_zero
                assign mcand_w[w][p] = 1'b0;
            end
        end
        for (genvar b = 0; b < XLEN; b++) begin : g_ext
            assign lo_w[w][b] = acc_q[(b / LW) * 2 * LW + (b % LW)];
            assign hi_w[w][b] = acc_q[(b / LW) * 2 * LW + LW + (b % LW)];
        end
    end

    always_comb begin
        mcand_sel = '0;
        lo_sel    = '0;
        hi_sel    = '0;
        for (int unsigned w = 0; w < PWW; w++) begin
            if (sel_in == 3'(w)) begin
                mcand_sel = mcand_w[w];
            end
            if (sel_q == 3'(w)) begin
                lo_sel = lo_w[w];
                hi_sel = hi_w[w];
            end
        end
    end

    p_mul_step #(
        .XLEN (XLEN),
        .BPS  (BPS),
        .PWW  (PWW)
    ) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .sel_i    (sel_q),
        .clmul_i  (clmul_q),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sel_d    = sel_q;
        mul_l_d  = mul_l_q;
        mul_h_d  = mul_h_q;
        clmul_d  = clmul_q;
        ready_d  = 1'b0;
        result_d = '0;
        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    state_d  = BUSY;
                    cnt_d    = '0;
                    acc_d    = '0;
                    mcand_d  = mcand_sel;
                    mplier_d = crs2;
                    sel_d    = sel_in;
                    mul_l_d  = mul_l;
                    mul_h_d  = mul_h;
                    clmul_d  = clmul;
                end
            end
            BUSY: begin
                if (!valid) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else if (cnt_q == steps) begin
                    // All N steps retired; this cycle latches the result so
                    // ready and result appear together in DONE.
                    state_d  = DONE;
                    ready_d  = 1'b1;
                    result_d = mul_l_q ? lo_sel : (mul_h_q ? hi_sel : '0);
                end else begin
                    acc_d    = step_acc;
                    mcand_d  = mcand_q << BPS;
                    mplier_d = mplier_q >> BPS;
                    cnt_d    = cnt_q + 7'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
                acc_d   = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sel_q    <= '0;
            mul_l_q  <= 1'b0;
            mul_h_q  <= 1'b0;
            clmul_q  <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sel_q    <= sel_d;
            mul_l_q  <= mul_l_d;
            mul_h_q  <= mul_h_d;
            clmul_q  <= clmul_d;
            ready_q  <= ready_d;
            result_q <= result_d;
        end
    end

    assign ready  = ready_q;
    assign result = result_q;

endmodule

// File: doc/p_mul_rx.md
P_MUL_RX -- requirements
Module: p_mul_rx

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand width; legal values 32 and 64.
REQ-002 SHALL have parameter BPS, default 1: multiplier bits retired per step; legal values 1, 2 and 4.
REQ-003 SHALL have derived parameter PWW = log2(XLEN): pw width, 5 or 6.
REQ-004 SHALL have port clock  in  1  single clock; all state on rising edge.
REQ-005 SHALL have port resetn  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port valid  in  1  request; held high until ready.
REQ-007 SHALL have port ready  out  1  single-cycle completion strobe; result valid this cycle.
REQ-008 SHALL have port mul_l  in  1  return low half of each lane product.
REQ-009 SHALL have port mul_h  in  1  return high half of each lane product.
REQ-010 SHALL have port clmul  in  1  carry-less (XOR) product instead of integer product.
REQ-011 SHALL have port pw  in  PWW  one-hot lane width; pw[i] selects lanes of XLEN>>i bits.
REQ-012 SHALL have port crs1  in  XLEN  multiplicand, packed lanes.
REQ-013 SHALL have port crs2  in  XLEN  multiplier, packed lanes.
REQ-014 SHALL have port result  out  XLEN  packed lane results.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-016 IDLE with valid=1 SHALL capture crs1, crs2, pw, mul_l, mul_h, clmul and enter BUSY; input changes after capture SHALL be ignored.
REQ-017 BUSY SHALL run N = LW/BPS steps, LW = lane width; after step N it SHALL enter DONE.
REQ-018 ready SHALL be high for exactly the one DONE cycle, N+1 cycles after the capturing edge; DONE SHALL always return to IDLE.
REQ-019 Each step SHALL process BPS multiplier bits per lane, LSB first, using unsigned lane arithmetic.
REQ-020 Each lane SHALL form a 2*LW-bit product; carries and partial products SHALL NOT cross lane boundaries.
REQ-021 With clmul=1, partial products SHALL be combined by XOR with no carry; otherwise by addition.
REQ-022 With mul_l=1, result SHALL hold each lane's low LW bits at the lane position; with mul_h=1 (mul_l=0), the high LW bits; mul_l SHALL take priority when both are set.
REQ-023 result SHALL be registered and SHALL read zero outside DONE.
REQ-024 valid dropping low in BUSY SHALL abort: next state IDLE, accumulator cleared, no ready.
REQ-025 valid low in DONE SHALL still complete the ready cycle, then IDLE.
REQ-026 Non-one-hot pw SHALL give undefined result but SHALL still complete: ready SHALL occur N+1 cycles after capture, taking N from the widest set bit.
REQ-027 Back-to-back: valid held high after DONE SHALL be captured in the IDLE cycle that follows.

Reset
REQ-028 resetn low SHALL asynchronously force state IDLE, step counter 0, accumulator 0, ready 0, result 0.
REQ-029 Reset in BUSY SHALL discard the operation; no ready SHALL follow.

Structure
REQ-030 Package p_mul_pkg SHALL hold the state enum, legal XLEN/BPS values and the lane-width-to-step-count function.
REQ-031 Combinational sub-module p_mul_step SHALL compute one BPS-bit step over all lanes (mask, shift, add or XOR); p_mul_rx SHALL hold the FSM, counter and registers.

Verification
REQ-032 XLEN=32, BPS=1, pw=32-bit, mul_l, crs1=crs2=0xFFFFFFFF -> result 0x00000001, ready 33 cycles after capture; repeated with mul_h -> 0xFFFFFFFE.
REQ-033 pw=8-bit, crs1=0x10FF0203, crs2=0x10FF0305: mul_l -> 0x0001060F, mul_h -> 0x01FE0000, ready after 9 cycles.
REQ-034 clmul, pw=32-bit, crs1=0xFFFFFFFF, crs2=0x00000003: mul_l -> 0x00000001, mul_h -> 0x00000001.
REQ-035 Abort: valid dropped after 5 BUSY cycles -> no ready; next op 3x5 (mul_l, 32-bit) -> 0x0000000F.
REQ-036 XLEN=64, BPS=4, pw=64-bit, mul_h, 0xFFFFFFFFFFFFFFFF squared -> 0xFFFFFFFFFFFFFFFE, ready after 17 cycles.
REQ-037 resetn pulsed low mid-BUSY -> ready, result and state zero/IDLE immediately; no ready follows.
